// File: rtl/packet_unpacker.sv
// Unpacks a {valid, check, data} packet and streams its bytes lowest-first over a
// valid/ready byte interface, tagging each byte with its recomputed parity status.
module packet_unpacker #(
   parameter int NBYTES   = 8,
   parameter int ERR_DROP = 0,
   localparam int IW      = (NBYTES > 1) ? $clog2(NBYTES) : 1,
   localparam int PW      = 9 * NBYTES + 1
) (
   input  logic          clock,
   input  logic          resetN,
   input  logic [PW-1:0] pkt_in,
   input  logic          pkt_load,
   output logic          pkt_ready,
   output logic [7:0]    byte_out,
   output logic          byte_valid,
   input  logic          byte_ready,
   output logic [IW-1:0] byte_index,
   output logic          byte_last,
   output logic          byte_perr,
   output logic [15:0]   err_count,
   output logic          dbg_state
);

   // Handshakes: a transfer happens on any rising edge where valid/load and ready
   // are both high; the offering side holds its data until that edge.
   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
   localparam logic          DROP     = (ERR_DROP != 0);

   state_t                state_q, state_d;
   logic [8*NBYTES-1:0]   data_q, data_d;
   logic [NBYTES-1:0]     mask_q, mask_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [15:0]           err_q, err_d;

   logic                  in_valid;
   logic [NBYTES-1:0]     in_check;
   logic [8*NBYTES-1:0]   in_data;
   logic [NBYTES-1:0]     in_mask;
   logic                  sending;
   logic                  at_last;
   logic                  accept;
   logic                  byte_hs;

   assign in_valid = pkt_in[9*NBYTES];
   assign in_check = pkt_in[9*NBYTES-1:8*NBYTES];
   assign in_data  = pkt_in[8*NBYTES-1:0];

   always_comb begin
      in_mask = '0;
      for (int i = 0; i < NBYTES; i++) begin
         in_mask[i] = in_check[i] ^ (^in_data[8*i +: 8]);
      end
   end

   assign sending   = (state_q == SEND);
   assign at_last   = sending && (idx_q == LAST_IDX);
   assign byte_hs   = sending && byte_ready;
   // Accepting on the last-byte handshake keeps back-to-back packets gapless.
   assign pkt_ready = !sending || (at_last && byte_ready);
   assign accept    = pkt_load && pkt_ready;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      mask_d  = mask_q;
      idx_d   = idx_q;
      err_d   = err_q;
      if (byte_hs) begin
         if (at_last) state_d = IDLE;
         else         idx_d   = idx_q + 1'b1;
      end
      if (accept) begin
         if (in_valid) begin
            data_d = in_data;
            mask_d = in_mask;
            idx_d  = '0;
            if ((|in_mask) && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
            state_d = (DROP && (|in_mask)) ? IDLE : SEND;
         end else begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q <= IDLE;
         data_q  <= '0;
         mask_q  <= '0;
         idx_q   <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         mask_q  <= mask_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

   assign byte_valid = sending;
   assign byte_out   = sending ? 8'(data_q >> {idx_q, 3'b000}) : 8'h00;
   assign byte_perr  = sending ? mask_q[idx_q] : 1'b0;
   assign byte_index = sending ? idx_q : '0;
   assign byte_last  = at_last;
   assign err_count  = err_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_packet_unpacker.sv
// Bench for packet_unpacker: one keep-errors and one drop-errors instance share stimulus
// and are each checked against a per-packet queue model of the expected byte stream.
module tb_packet_unpacker;

   logic        clock = 1'b0;
   logic        resetN;
   logic [72:0] pkt_in;
   logic        pkt_load;
   logic        byte_ready;

   logic        pkt_ready_w [2];
   logic [7:0]  byte_out_w [2];
   logic        byte_valid_w [2];
   logic [2:0]  byte_index_w [2];
   logic        byte_last_w [2];
   logic        byte_perr_w [2];
   logic [15:0] err_count_w [2];
   logic        dbg_state_w [2];

   int n_checks = 0;
   int n_fail   = 0;

   // Expected entries: {perr, last, index[2:0], byte[7:0]}
   logic [12:0] exp_q0[$];
   logic [12:0] exp_q1[$];
   logic [15:0] exp_err [2];

   always #5 clock = ~clock;

   packet_unpacker #(.NBYTES(8), .ERR_DROP(0)) u_keep (
      .clock(clock), .resetN(resetN), .pkt_in(pkt_in), .pkt_load(pkt_load),
      .pkt_ready(pkt_ready_w[0]), .byte_out(byte_out_w[0]), .byte_valid(byte_valid_w[0]),
      .byte_ready(byte_ready), .byte_index(byte_index_w[0]), .byte_last(byte_last_w[0]),
      .byte_perr(byte_perr_w[0]), .err_count(err_count_w[0]), .dbg_state(dbg_state_w[0])
   );

   packet_unpacker #(.NBYTES(8), .ERR_DROP(1)) u_drop (
      .clock(clock), .resetN(resetN), .pkt_in(pkt_in), .pkt_load(pkt_load),
      .pkt_ready(pkt_ready_w[1]), .byte_out(byte_out_w[1]), .byte_valid(byte_valid_w[1]),
      .byte_ready(byte_ready), .byte_index(byte_index_w[1]), .byte_last(byte_last_w[1]),
      .byte_perr(byte_perr_w[1]), .err_count(err_count_w[1]), .dbg_state(dbg_state_w[1])
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Packet with correct even parity per byte, then check bits XORed with flip.
   function automatic logic [72:0] make_pkt(input logic [63:0] d, input bit v, input logic [7:0] flip);
      logic [7:0] chk;
      for (int i = 0; i < 8; i++) chk[i] = ($countones(d[8*i +: 8]) % 2) == 1;
      return {v, chk ^ flip, d};
   endfunction

   // One cycle of the reference: compare outputs, then advance to the next edge.
   task automatic model_step(input int k);
      logic [12:0] q[$];
      bit          busy, exp_rdy, bad;
      logic [7:0]  m;
      logic [7:0]  b;
      q = (k == 0) ? exp_q0 : exp_q1;
      busy = (q.size() != 0);
      check_eq($sformatf("i%0d byte_valid", k), byte_valid_w[k], busy);
      check_eq($sformatf("i%0d state", k), dbg_state_w[k], busy);
      if (busy) begin
         check_eq($sformatf("i%0d byte_out", k), byte_out_w[k], q[0][7:0]);
         check_eq($sformatf("i%0d byte_index", k), byte_index_w[k], q[0][10:8]);
         check_eq($sformatf("i%0d byte_last", k), byte_last_w[k], q[0][11]);
         check_eq($sformatf("i%0d byte_perr", k), byte_perr_w[k], q[0][12]);
      end
      exp_rdy = !busy || (q.size() == 1 && byte_ready);
      check_eq($sformatf("i%0d pkt_ready", k), pkt_ready_w[k], exp_rdy);
      check_eq($sformatf("i%0d err_count", k), err_count_w[k], exp_err[k]);
      if (busy && byte_ready) void'(q.pop_front());
      if (pkt_load && exp_rdy && pkt_in[72]) begin
         for (int i = 0; i < 8; i++) begin
            b = pkt_in[8*i +: 8];
            m[i] = (($countones(b) % 2) == 1) != pkt_in[64+i];
         end
         bad = (m != 8'h00);
         if (bad && exp_err[k] != 16'hFFFF) exp_err[k] = exp_err[k] + 16'd1;
         if (!(k == 1 && bad)) begin
            for (int i = 0; i < 8; i++) q.push_back({m[i], i == 7, 3'(i), pkt_in[8*i +: 8]});
         end
      end
      if (k == 0) exp_q0 = q;
      else        exp_q1 = q;
   endtask

   always @(negedge clock) begin
      if (resetN) begin
         model_step(0);
         model_step(1);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int k = 0; k < 2; k++) begin
         check_eq($sformatf("%s i%0d valid", tag, k), byte_valid_w[k], 1'b0);
         check_eq($sformatf("%s i%0d out", tag, k), byte_out_w[k], 8'h00);
         check_eq($sformatf("%s i%0d index", tag, k), byte_index_w[k], 3'd0);
         check_eq($sformatf("%s i%0d last", tag, k), byte_last_w[k], 1'b0);
         check_eq($sformatf("%s i%0d perr", tag, k), byte_perr_w[k], 1'b0);
         check_eq($sformatf("%s i%0d err", tag, k), err_count_w[k], 16'h0000);
      end
   endtask

   task automatic do_reset();
      #1;
      resetN   = 1'b0;
      pkt_load = 1'b0;
      #1;
      check_reset_outputs("reset");
      exp_q0.delete();
      exp_q1.delete();
      exp_err[0] = '0;
      exp_err[1] = '0;
      tick();
      resetN = 1'b1;
   endtask

   task automatic pulse_pkt(input logic [72:0] p);
      pkt_in   = p;
      pkt_load = 1'b1;
      tick();
      pkt_load = 1'b0;
   endtask

   logic [72:0] nominal, corrupt, pkt_b;
   bit          found;

   initial begin
      resetN = 1'b0; pkt_load = 1'b0; byte_ready = 1'b1; pkt_in = '0;
      exp_err[0] = '0; exp_err[1] = '0;
      nominal = {1'b1, 8'b00001011, 64'd16777732};
      corrupt = {1'b1, 8'b00001010, 64'd16777732};
      repeat (3) tick();
      check_reset_outputs("init");
      resetN = 1'b1;
      tick();
      check_eq("ready after reset", pkt_ready_w[0], 1'b1);

      // Nominal packet: byte 0 appears the cycle after accept.
      pulse_pkt(nominal);
      check_eq("nominal first valid", byte_valid_w[0], 1'b1);
      check_eq("nominal first byte", byte_out_w[0], 8'd4);
      repeat (10) tick();

      // Corrupt check: streamed with perr on byte 0 by one, dropped by the other.
      pulse_pkt(corrupt);
      check_eq("corrupt keep perr0", byte_perr_w[0], 1'b1);
      check_eq("corrupt drop no valid", byte_valid_w[1], 1'b0);
      check_eq("corrupt drop ready", pkt_ready_w[1], 1'b1);
      check_eq("corrupt keep err", err_count_w[0], 16'd1);
      check_eq("corrupt drop err", err_count_w[1], 16'd1);
      repeat (9) tick();
      pulse_pkt(nominal);
      check_eq("clean after drop", byte_out_w[1], 8'd4);
      repeat (9) tick();

      // Back-pressure at index 2, then back-to-back acceptance on the last byte.
      pkt_b = make_pkt({$urandom, $urandom}, 1'b1, 8'h00);
      pulse_pkt(nominal);
      pkt_in = pkt_b; pkt_load = 1'b1;
      found = 0;
      for (int n = 0; n < 10 && !found; n++) begin
         if (byte_index_w[0] == 3'd2) found = 1;
         else tick();
      end
      check_eq("reach index 2", found, 1'b1);
      byte_ready = 1'b0;
      repeat (3) begin
         tick();
         check_eq("stall index", byte_index_w[0], 3'd2);
         check_eq("stall byte", byte_out_w[0], 8'd0);
      end
      byte_ready = 1'b1;
      found = 0;
      for (int n = 0; n < 12 && !found; n++) begin
         if (pkt_ready_w[0]) found = 1;
         else tick();
      end
      check_eq("b2b ready seen", found, 1'b1);
      check_eq("b2b on last", byte_last_w[0], 1'b1);
      tick();
      pkt_load = 1'b0;
      check_eq("b2b no gap", byte_valid_w[0], 1'b1);
      check_eq("b2b index0", byte_index_w[0], 3'd0);
      check_eq("b2b byte0", byte_out_w[0], pkt_b[7:0]);
      repeat (10) tick();

      // Valid bit 0: consumed with no output.
      check_eq("invalid ready", pkt_ready_w[0], 1'b1);
      pulse_pkt(make_pkt({$urandom, $urandom}, 1'b0, 8'h5A));
      check_eq("invalid no valid", byte_valid_w[0], 1'b0);
      check_eq("invalid err held", err_count_w[0], exp_err[0]);
      repeat (2) tick();

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         pkt_in = make_pkt({$urandom, $urandom}, $urandom_range(0, 9) < 8,
                           ($urandom_range(0, 9) < 3) ? 8'($urandom_range(1, 255)) : 8'h00);
         pkt_load   = $urandom_range(0, 1);
         byte_ready = $urandom_range(0, 3) != 0;
         tick();
      end
      pkt_load = 1'b0; byte_ready = 1'b1;
      repeat (10) tick();

      // Reset mid-packet at index 4; next packet restarts at index 0.
      pulse_pkt(nominal);
      found = 0;
      for (int n = 0; n < 10 && !found; n++) begin
         if (byte_index_w[0] == 3'd4) found = 1;
         else tick();
      end
      check_eq("reach index 4", found, 1'b1);
      do_reset();
      tick();
      pulse_pkt(nominal);
      check_eq("post reset index", byte_index_w[0], 3'd0);
      check_eq("post reset valid", byte_valid_w[0], 1'b1);
      repeat (9) tick();

      // Saturation of the error counter.
      pkt_in = corrupt; pkt_load = 1'b1; byte_ready = 1'b1;
      repeat (65540) tick();
      pkt_load = 1'b0;
      repeat (10) tick();
      check_eq("saturate drop", err_count_w[1], 16'hFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/packet_unpacker.md
# packet_unpacker

Downstream consumer of the 73-bit packed packet produced by the packet fill stage (`{valid, check[7:0], data[63:0]}`). It accepts one packet per handshake and re-checks the per-byte parity. It then streams the eight data bytes out one per cycle, lowest byte first, over a valid/ready byte interface, tagging each byte with its parity status. Optionally it drops corrupted packets and keeps a saturating error count.

## Interface

Parameters:
- `NBYTES`, default 8: bytes per packet. Packet width is 9*NBYTES+1.
- `ERR_DROP`, default 0: 1 means a packet with any parity mismatch is discarded whole; 0 means it is streamed with per-byte error flags.

Ports:
- `clock`  in  1: single clock, rising edge.
- `resetN`  in  1: asynchronous, active-low reset.
- `pkt_in`  in  9*NBYTES+1: packet. Bit [9*NBYTES] = valid; [9*NBYTES-1:8*NBYTES] = check; [8*NBYTES-1:0] = data. Byte i is at data[8i+:8]; check[i] is the even-XOR of byte i.
- `pkt_load`  in  1: upstream offers `pkt_in` this cycle.
- `pkt_ready`  out  1: block can accept `pkt_in` this cycle.
- `byte_out`  out  8: current output byte.
- `byte_valid`  out  1: `byte_out` is valid.
- `byte_ready`  in  1: downstream accepts the byte.
- `byte_index`  out  $clog2(NBYTES): index of `byte_out` within its packet.
- `byte_last`  out  1: `byte_out` is byte NBYTES-1.
- `byte_perr`  out  1: stored check bit for this byte disagrees with recomputed parity.
- `err_count`  out  16: packets with at least one parity mismatch, saturating.

## Operation

- **State machine.** Two states, IDLE and SEND.
- **Accept.** A packet is accepted when `pkt_load && pkt_ready`.
  - `pkt_ready` = (state==IDLE) OR (state==SEND && byte_last && byte_valid && byte_ready). The second term gives back-to-back acceptance and is combinational from `byte_ready`.
- **Valid bit 0.** An accepted packet whose valid bit is 0 is consumed and discarded. Next state is IDLE, no counters change.
- **Valid bit 1, on acceptance:**
  - Register data.
  - Compute mismatch mask m[i] = check[i] ^ (^data[8i+:8]) and register it.
  - Set index = 0.
  - If m != 0, increment `err_count` (hold at 16'hFFFF).
  - If ERR_DROP==1 and m != 0, discard and go to IDLE. Otherwise go to SEND.
- **In SEND:**
  - `byte_valid` = 1.
  - `byte_out` = data[8*index+:8], `byte_perr` = m[index], `byte_index` = index, `byte_last` = (index==NBYTES-1).
  - On `byte_valid && byte_ready`:
    - If not last, index increments.
    - If last: go to SEND with new data when a new valid packet is accepted that same cycle (unless it is dropped); otherwise go to IDLE.
- **Back-pressure.** While `byte_ready` is 0, all byte outputs hold stable.
- **Outputs in IDLE.** `byte_valid` = 0. `byte_out`, `byte_index`, `byte_perr` and `byte_last` are don't-care; the implementation drives them to 0.

## Timing

- **Reset.** Reset asserted forces, asynchronously:
  - state = IDLE, index = 0, data = 0, m = 0, `err_count` = 0;
  - `byte_valid` = 0, `byte_out` = 0, `byte_index` = 0, `byte_last` = 0, `byte_perr` = 0;
  - `pkt_ready` = 1 once reset is released.
- **Reset mid-packet.** Reset during SEND abandons the remaining bytes; no partial packet resumes.
- **Latency.** A packet accepted at rising edge N presents byte 0 on `byte_valid` during cycle N+1. With `byte_ready` held 1, byte k is presented in cycle N+1+k.
- **Throughput.** One byte per cycle. With continuous `pkt_load`, valid packets and `byte_ready` = 1, there are no bubbles between packets: NBYTES cycles per packet.
- **Drops.** A dropped packet (ERR_DROP, or valid bit 0) costs one accept cycle and produces no `byte_valid`.
- **Counter update.** `err_count` updates at the accept edge, including for dropped packets, and also when acceptance happens at a last-byte handshake.

## Test plan

1. **Nominal packet.** Load data bytes [0..7] = 4,2,0,1,0,0,0,0 (data = 16777732), check = 8'b00001011, valid = 1, with `byte_ready` = 1.
   - Required: `byte_out` = 4,2,0,1,0,0,0,0 in 8 consecutive cycles starting one cycle after accept.
   - `byte_perr` = 0 throughout, `byte_last` only on index 7, `err_count` = 0.
2. **Corrupt check, ERR_DROP=0.** Same packet with check = 8'b00001010.
   - Required: `byte_perr` = 1 only on byte 0, `err_count` = 1, all 8 bytes still delivered.
3. **Corrupt check, ERR_DROP=1.** Same corrupt packet.
   - Required: no `byte_valid`, `err_count` = 1, `pkt_ready` = 1 on the next cycle.
   - A following clean packet streams normally.
4. **Back-pressure and back-to-back.**
   - Drop `byte_ready` for 3 cycles at index 2: `byte_out` and `byte_index` stay 0 and 2.
   - Hold `pkt_load` with a second packet: it is accepted exactly at the last-byte handshake, and its byte 0 follows in the next cycle with no gap.
5. **Valid bit 0.** Offer a packet with valid bit 0.
   - Required: accepted (`pkt_ready` = 1), no byte output, `err_count` unchanged.
6. **Reset and saturation.**
   - Assert `resetN` low at index 4: all outputs go to their reset values immediately, and the next packet starts at index 0.
   - Force 65536 corrupt packets: `err_count` holds at 16'hFFFF.
